// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the execute unit and the ALU_Control decoder:
//   - 4-bit ALU control codes
//   - execute FSM state encoding
//   - helper that recognises the shift codes
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic is_shift_code(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
//   Purely combinational ALU: AND/OR/ADD/SUB/SLT and a one-step barrel shifter,
//   plus decode of undefined control codes.
// Ports
//   ctrl      in   4     ALU control code
//   op_a      in   XLEN  operand A
//   op_b      in   XLEN  operand B (shifts use op_b[SHW-1:0])
//   result    out  XLEN  result; 0 for undefined codes
//   illegal   out  1     ctrl is not a defined code
//   is_shift  out  1     ctrl is SLL/SRL/SRA
// -----------------------------------------------------------------------------
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result,
   output logic            illegal,
   output logic            is_shift
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;

   assign shamt    = op_b[SHW-1:0];
   assign is_shift = is_shift_code(ctrl);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (ctrl)
         ALU_AND: result = op_a & op_b;
         ALU_OR:  result = op_a | op_b;
         ALU_ADD: result = op_a + op_b;
         ALU_SUB: result = op_a - op_b;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLL: result = op_a << shamt;
         ALU_SRL: result = op_a >> shamt;
         ALU_SRA: result = XLEN'($signed(op_a) >>> shamt);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Multi-cycle RV32 execute unit. One-cycle logic/arith/SLT ops; shifts either
//   iterate one bit per cycle (FAST_SHIFT=0) or complete in one cycle.
//   Valid/ready on input and output; one op in flight at a time.
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   flush      in   1     synchronous abort of any in-flight op
//   in_valid   in   1     ctrl/op_a/op_b valid
//   in_ready   out  1     unit can accept an op this cycle
//   ctrl       in   4     ALU control code
//   op_a       in   XLEN  operand A
//   op_b       in   XLEN  operand B
//   out_valid  out  1     result/zero/illegal valid
//   out_ready  in   1     consumer takes result this cycle
//   result     out  XLEN  registered result
//   zero       out  1     result == 0 (drives beq)
//   illegal    out  1     ctrl was not a defined code
//   busy       out  1     unit is not idle
// -----------------------------------------------------------------------------
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit FAST_SHIFT = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);

   state_t          state, state_nxt;
   logic [SHW-1:0]  cnt;
   logic [XLEN-1:0] sreg;
   logic [XLEN-1:0] sreg_nxt;
   logic [3:0]      sop;

   logic [XLEN-1:0] core_result;
   logic            core_illegal;
   logic            core_is_shift;

   logic [SHW-1:0]  shamt;
   logic            accept;
   logic            go_iter;
   logic            shift_last;

   alu_comb_core #(.XLEN(XLEN)) u_core (
      .ctrl     (ctrl),
      .op_a     (op_a),
      .op_b     (op_b),
      .result   (core_result),
      .illegal  (core_illegal),
      .is_shift (core_is_shift)
   );

   assign shamt      = op_b[SHW-1:0];
   assign out_valid  = (state == ST_DONE);
   assign busy       = (state != ST_IDLE);
   assign shift_last = (state == ST_SHIFT) && (cnt == SHW'(1));

   // One-bit step of the iterative shifter, selected by the latched opcode.
   always_comb begin
      sreg_nxt = sreg >> 1;
      case (sop)
         ALU_SLL: sreg_nxt = sreg << 1;
         ALU_SRA: sreg_nxt = {sreg[XLEN-1], sreg[XLEN-1:1]};
         default: ;
      endcase
   end

   // in_ready is forced low during reset so nothing is accepted while the
   // registers are being cleared.
   always_comb begin
      state_nxt = state;
      in_ready  = rst_n && (state == ST_IDLE) && !flush;
      accept    = in_valid && in_ready;
      go_iter   = accept && core_is_shift && !FAST_SHIFT && (shamt != '0);
      if (flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (accept)     state_nxt = go_iter ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (shift_last) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
         sreg    <= '0;
         cnt     <= '0;
         sop     <= ALU_AND;
      end else if (flush) begin
         // Abort: result/zero keep their last committed value.
         illegal <= 1'b0;
      end else if (accept) begin
         if (go_iter) begin
            sreg    <= op_a;
            cnt     <= shamt;
            sop     <= ctrl;
            illegal <= 1'b0;
         end else begin
            result  <= core_result;
            zero    <= (core_result == '0);
            illegal <= core_illegal;
         end
      end else if (state == ST_SHIFT) begin
         sreg <= sreg_nxt;
         cnt  <= cnt - SHW'(1);
         if (shift_last) begin
            result <= sreg_nxt;
            zero   <= (sreg_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed stimulus for alu_exec_unit (XLEN=32, FAST_SHIFT=0). A cycle-level
//   behavioural model predicts handshake and result; a compare process checks
//   the DUT against it every cycle, and directed checks pin literal values.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

   localparam int XLEN = 32;
   localparam bit FAST = 1'b0;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [3:0]      ctrl = 4'd0;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            in_ready;
   logic            out_valid;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;
   logic            busy;

   int n_checks = 0;
   int n_errors = 0;

   alu_exec_unit #(.XLEN(XLEN), .FAST_SHIFT(FAST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ctrl      (ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU straight from the opcode table: {illegal, result}.
   function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (c)
         4'b0000: return {1'b0, a & b};
         4'b0001: return {1'b0, a | b};
         4'b0010: return {1'b0, a + b};
         4'b0110: return {1'b0, a - b};
         4'b0111: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
         4'b1000: return {1'b0, a << sh};
         4'b1001: return {1'b0, a >> sh};
         4'b1010: return {1'b0, 32'($signed(a) >>> sh)};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_BUSY, M_DONE} mph_t;
   mph_t        m_ph = M_IDLE;
   int          m_wait = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_result = '0;
   logic        m_zero = 1'b0;
   logic        m_illegal = 1'b0;
   logic [32:0] m_r;
   int          m_lat;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = M_IDLE; m_wait = 0; m_result = '0; m_zero = 1'b0; m_illegal = 1'b0;
      end else if (flush) begin
         m_ph = M_IDLE; m_illegal = 1'b0;
      end else begin
         case (m_ph)
            M_IDLE: if (in_valid) begin
               m_r   = ref_alu(ctrl, op_a, op_b);
               m_lat = (!FAST && (ctrl == 4'b1000 || ctrl == 4'b1001 || ctrl == 4'b1010))
                       ? int'(op_b[4:0]) : 0;
               if (m_lat == 0) begin
                  m_ph = M_DONE; m_result = m_r[31:0]; m_zero = (m_r[31:0] == 0); m_illegal = m_r[32];
               end else begin
                  m_ph = M_BUSY; m_wait = m_lat; m_pend = m_r[31:0]; m_illegal = 1'b0;
               end
            end
            M_BUSY: begin
               m_wait--;
               if (m_wait == 0) begin
                  m_ph = M_DONE; m_result = m_pend; m_zero = (m_pend == 0);
               end
            end
            M_DONE: if (out_ready) m_ph = M_IDLE;
            default: m_ph = M_IDLE;
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("out_valid", out_valid, m_ph == M_DONE);
      check("busy", busy, m_ph != M_IDLE);
      check("in_ready", in_ready, rst_n && (m_ph == M_IDLE) && !flush);
      check("result", result, m_result);
      check("zero", zero, m_zero);
      if (m_ph == M_DONE) check("illegal", illegal, m_illegal);
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int guard;
      guard = 0;
      @(negedge clk); #1;
      ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk); #1;
         guard++;
      end
      check("accept_wait", 32'(guard < 50), 1);
      @(posedge clk); #1;
      // Scramble operands after the accept edge; they must not matter.
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom; ctrl = 4'($urandom);
   endtask

   // Counts cycles after the accept edge before out_valid rises.
   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_wait", 32'(n < 100), 1);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   int n;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #2;
      check("rst_result", result, 32'h0);
      check("rst_zero", zero, 0);
      check("rst_illegal", illegal, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // 1. ADD wraps into the sign bit, one-cycle latency
      issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
      wait_done(n);
      check("add_lat", n, 0);
      check("add_res", result, 32'h8000_0000);
      check("add_zero", zero, 0);
      check("add_illegal", illegal, 0);
      take();

      // 2. SUB to zero, signed SLT
      issue(4'b0110, 32'h1234, 32'h1234);
      wait_done(n);
      check("sub_res", result, 32'h0);
      check("sub_zero", zero, 1);
      take();
      issue(4'b0111, 32'hFFFF_FFFF, 32'h0);
      wait_done(n);
      check("slt_res", result, 32'h1);
      check("slt_zero", zero, 0);
      take();
      issue(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F);
      wait_done(n);
      check("or_res", result, 32'hF0F0_0F0F);
      take();

      // 3. Iterative shifts
      issue(4'b1010, 32'h8000_0000, 32'h4);
      wait_done(n);
      check("sra_lat", n, 4);
      check("sra_res", result, 32'hF800_0000);
      take();
      issue(4'b1000, 32'hA5A5_0001, 32'h20);   // shamt bits are 0
      wait_done(n);
      check("sll0_lat", n, 0);
      check("sll0_res", result, 32'hA5A5_0001);
      take();
      issue(4'b1001, 32'hF000_0000, 32'h1F);
      wait_done(n);
      check("srl31_lat", n, 31);
      check("srl31_res", result, 32'h1);
      take();
      issue(4'b1000, 32'h3, 32'h1F);
      wait_done(n);
      check("sll31_res", result, 32'h8000_0000);
      take();

      // 4. Undefined code, then a legal op clears illegal
      issue(4'b0011, 32'h1111, 32'h2222);
      wait_done(n);
      check("ill_flag", illegal, 1);
      check("ill_res", result, 32'h0);
      check("ill_zero", zero, 1);
      take();
      issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
      wait_done(n);
      check("and_res", result, 32'h0F00_0F00);
      check("and_illegal", illegal, 0);
      take();

      // 5. Stall in DONE for 5 cycles
      issue(4'b0010, 32'd5, 32'd6);
      wait_done(n);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_valid", out_valid, 1);
         check("stall_res", result, 32'd11);
         check("stall_in_ready", in_ready, 0);
      end
      take();
      check("post_take_in_ready", in_ready, 1);
      check("post_take_valid", out_valid, 0);

      // flush beats out_ready
      issue(4'b0001, 32'h0, 32'h40);
      wait_done(n);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b0;
      check("flush_done_valid", out_valid, 0);
      check("flush_done_res", result, 32'h40);
      // flush beats in_valid
      @(negedge clk); #1;
      ctrl = 4'b0010; op_a = 32'h1; op_b = 32'h1; in_valid = 1'b1; flush = 1'b1;
      #1 check("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_no_accept", busy, 0);

      // 6. flush in cycle 2 of SRL shamt=31
      issue(4'b1001, 32'hFFFF_FFFF, 32'h1F);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_shift_busy", busy, 0);
      check("flush_shift_valid", out_valid, 0);
      check("flush_shift_res", result, 32'h40);
      repeat (3) @(posedge clk);

      // Async reset mid-SHIFT
      issue(4'b1000, 32'h1, 32'hA);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_result", result, 32'h0);
      check("arst_busy", busy, 0);
      check("arst_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 0);
      check("arst_zero", zero, 0);
      check("arst_illegal", illegal, 0);
      @(negedge clk); #1 rst_n = 1'b1;

      issue(4'b0110, 32'h0, 32'h1);
      wait_done(n);
      check("final_sub", result, 32'hFFFF_FFFF);
      take();

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
